// File: rtl/plab2_proc_imem_dmem_arbiter_if.sv
// Memory request/response channel: val/rdy request and response halves.
// The master issues requests and consumes responses; the slave does the opposite.
interface plab2_proc_imem_dmem_arbiter_if #(
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 32
);
  localparam int unsigned len_nbits  = $clog2(p_data_nbits / 8);
  localparam int unsigned req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + len_nbits
                                       + p_data_nbits;
  localparam int unsigned resp_nbits = 3 + p_opaque_nbits + 2 + len_nbits + p_data_nbits;

  logic [req_nbits-1:0]  req_msg;
  logic                  req_val;
  logic                  req_rdy;
  logic [resp_nbits-1:0] resp_msg;
  logic                  resp_val;
  logic                  resp_rdy;

  modport master (
    output req_msg, req_val, resp_rdy,
    input  req_rdy, resp_msg, resp_val
  );

  modport slave (
    input  req_msg, req_val, resp_rdy,
    output req_rdy, resp_msg, resp_val
  );
endinterface

// File: rtl/plab2_proc_imem_dmem_arbiter.sv
// Round-robin arbiter sharing one memory port between imem and dmem. A tag FIFO
// records each accepted request's owner so in-order responses return to it.
module plab2_proc_imem_dmem_arbiter #(
  parameter int unsigned p_opaque_nbits    = 8,
  parameter int unsigned p_addr_nbits      = 32,
  parameter int unsigned p_data_nbits      = 32,
  parameter int unsigned p_max_outstanding = 4,
  localparam int unsigned cnt_nbits        = $clog2(p_max_outstanding) + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  plab2_proc_imem_dmem_arbiter_if.slave         imem,
  plab2_proc_imem_dmem_arbiter_if.slave         dmem,
  plab2_proc_imem_dmem_arbiter_if.master        mem,
  output logic [cnt_nbits-1:0]                  num_outstanding
);

  localparam int unsigned ptr_nbits = $clog2(p_max_outstanding);
  localparam int unsigned req_nbits = 3 + p_opaque_nbits + p_addr_nbits
                                      + $clog2(p_data_nbits / 8) + p_data_nbits;

  logic                 prio_q;
  logic                 tags_q [p_max_outstanding];
  logic [ptr_nbits-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_nbits-1:0] count_q;

  logic                 full, empty, any_val, winner, head, grant_ok;
  logic                 req_fire, resp_fire;
  logic [req_nbits-1:0] win_msg;

  assign full    = (count_q == cnt_nbits'(p_max_outstanding));
  assign empty   = (count_q == '0);
  assign any_val = imem.req_val | dmem.req_val;
  // With both valid, prio picks; otherwise the lone valid one (imem when idle).
  assign winner  = (imem.req_val & dmem.req_val) ? prio_q : dmem.req_val;
  // Acceptance depends only on registered occupancy: no resp-to-req rdy path.
  assign grant_ok = ~full & reset;
  assign win_msg  = winner ? dmem.req_msg : imem.req_msg;

  assign mem.req_msg  = win_msg;
  assign mem.req_val  = any_val & grant_ok;
  assign imem.req_rdy = any_val & ~winner & mem.req_rdy & grant_ok;
  assign dmem.req_rdy = any_val &  winner & mem.req_rdy & grant_ok;
  assign req_fire     = mem.req_val & mem.req_rdy;

  assign head          = tags_q[rd_ptr_q];
  assign imem.resp_msg = mem.resp_msg;
  assign dmem.resp_msg = mem.resp_msg;
  assign imem.resp_val = mem.resp_val & ~empty & ~head;
  assign dmem.resp_val = mem.resp_val & ~empty &  head;
  assign mem.resp_rdy  = ~empty & (head ? dmem.resp_rdy : imem.resp_rdy);
  assign resp_fire     = mem.resp_val & mem.resp_rdy;

  assign num_outstanding = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(p_max_outstanding); i++) tags_q[i] <= 1'b0;
    end else begin
      if (req_fire) begin
        tags_q[wr_ptr_q] <= winner;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        prio_q           <= ~winner;
      end
      if (resp_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({req_fire, resp_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_plab2_proc_imem_dmem_arbiter.sv
// Directed bench for the imem/dmem arbiter: drives the memory side by hand and
// checks grant order, tag routing, full/empty blocking and async reset.
module tb_plab2_proc_imem_dmem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] num_outstanding;

  int n_checks = 0;
  int n_pass   = 0;

  plab2_proc_imem_dmem_arbiter_if imem_if ();
  plab2_proc_imem_dmem_arbiter_if dmem_if ();
  plab2_proc_imem_dmem_arbiter_if mem_if ();

  plab2_proc_imem_dmem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .imem            (imem_if.slave),
    .dmem            (dmem_if.slave),
    .mem             (mem_if.master),
    .num_outstanding (num_outstanding)
  );

  always #5 clk = ~clk;

  function automatic logic [76:0] mk_req(input logic [7:0] opq, input logic [31:0] addr);
    return {3'd0, opq, addr, 2'd0, 32'd0};
  endfunction

  function automatic logic [46:0] mk_resp(input logic [7:0] opq, input logic [31:0] data);
    return {3'd0, opq, 2'd0, 2'd0, data};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [76:0] im_msg, dm_msg;
  logic [46:0] rsp;
  int          ii, di;

  initial begin
    reset = 1'b0;
    imem_if.req_msg = '0; imem_if.req_val = 1'b0; imem_if.resp_rdy = 1'b0;
    dmem_if.req_msg = '0; dmem_if.req_val = 1'b0; dmem_if.resp_rdy = 1'b0;
    mem_if.req_rdy  = 1'b1; mem_if.resp_msg = '0; mem_if.resp_val = 1'b0;

    // Reset: outputs held low even with requesters and memory asserting.
    #2;
    imem_if.req_val = 1'b1;
    mem_if.resp_val = 1'b1;
    #1;
    chk("rst_memreq_val", mem_if.req_val, 0);
    chk("rst_imemreq_rdy", imem_if.req_rdy, 0);
    chk("rst_memresp_rdy", mem_if.resp_rdy, 0);
    chk("rst_imemresp_val", imem_if.resp_val, 0);
    chk("rst_num_out", num_outstanding, 0);
    imem_if.req_val = 1'b0;
    mem_if.resp_val = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // imem-only stream of 4 reads.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      im_msg = mk_req(8'(i), 32'h200 + 32'(4 * i));
      imem_if.req_msg = im_msg;
      imem_if.req_val = 1'b1;
      #1;
      chk("s1_memreq_val", mem_if.req_val, 1);
      chk("s1_memreq_msg", mem_if.req_msg, im_msg);
      chk("s1_imemreq_rdy", imem_if.req_rdy, 1);
      chk("s1_dmemreq_rdy", dmem_if.req_rdy, 0);
    end
    @(negedge clk);
    imem_if.req_val = 1'b0;
    imem_if.resp_rdy = 1'b1;
    dmem_if.resp_rdy = 1'b1;
    #1;
    chk("s1_peak", num_outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      rsp = mk_resp(8'(i), 32'hA0 + 32'(i));
      mem_if.resp_msg = rsp;
      mem_if.resp_val = 1'b1;
      #1;
      chk("s1_imemresp_val", imem_if.resp_val, 1);
      chk("s1_dmemresp_val", dmem_if.resp_val, 0);
      chk("s1_imemresp_msg", imem_if.resp_msg, rsp);
      chk("s1_memresp_rdy", mem_if.resp_rdy, 1);
    end
    @(negedge clk);
    mem_if.resp_val = 1'b0;
    #1;
    chk("s1_drained", num_outstanding, 0);

    // Both valid every cycle: grants dmem, imem, dmem, imem.
    ii = 0;
    di = 0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      im_msg = mk_req(8'h10 + 8'(ii), 32'h300 + 32'(4 * ii));
      dm_msg = mk_req(8'h20 + 8'(di), 32'h400 + 32'(4 * di));
      imem_if.req_msg = im_msg;
      dmem_if.req_msg = dm_msg;
      imem_if.req_val = 1'b1;
      dmem_if.req_val = 1'b1;
      #1;
      if (s % 2 == 0) begin
        chk("s2_msg_d", mem_if.req_msg, dm_msg);
        chk("s2_drdy", dmem_if.req_rdy, 1);
        chk("s2_irdy0", imem_if.req_rdy, 0);
        di++;
      end else begin
        chk("s2_msg_i", mem_if.req_msg, im_msg);
        chk("s2_irdy", imem_if.req_rdy, 1);
        chk("s2_drdy0", dmem_if.req_rdy, 0);
        ii++;
      end
    end

    // Full: pending imem request stalls, even in the cycle a response pops.
    @(negedge clk);
    dmem_if.req_val = 1'b0;
    im_msg = mk_req(8'h55, 32'h500);
    imem_if.req_msg = im_msg;
    #1;
    chk("s3_full_cnt", num_outstanding, 4);
    chk("s3_full_val", mem_if.req_val, 0);
    chk("s3_full_irdy", imem_if.req_rdy, 0);
    chk("s3_full_drdy", dmem_if.req_rdy, 0);
    @(negedge clk);
    rsp = mk_resp(8'h20, 32'hD0);
    mem_if.resp_msg = rsp;
    mem_if.resp_val = 1'b1;
    #1;
    chk("s3_route_d", dmem_if.resp_val, 1);
    chk("s3_route_i0", imem_if.resp_val, 0);
    chk("s3_dmsg", dmem_if.resp_msg, rsp);
    chk("s3_resp_rdy", mem_if.resp_rdy, 1);
    chk("s3_still_stall", mem_if.req_val, 0);
    @(negedge clk);
    mem_if.resp_val = 1'b0;
    #1;
    chk("s3_cnt3", num_outstanding, 3);
    chk("s3_accept_val", mem_if.req_val, 1);
    chk("s3_accept_rdy", imem_if.req_rdy, 1);
    chk("s3_accept_msg", mem_if.req_msg, im_msg);
    // FIFO now holds tags i, d, i, i.

    // Pop the imem head so a dmem tag reaches the head.
    @(negedge clk);
    imem_if.req_val = 1'b0;
    mem_if.resp_val = 1'b1;
    #1;
    chk("s4_i_head", imem_if.resp_val, 1);
    @(negedge clk);
    dmem_if.resp_rdy = 1'b0;
    #1;
    chk("s4_hol_rdy", mem_if.resp_rdy, 0);
    chk("s4_hol_dval", dmem_if.resp_val, 1);
    chk("s4_hol_ival", imem_if.resp_val, 0);
    @(negedge clk);
    #1;
    chk("s4_no_pop", num_outstanding, 3);
    dmem_if.resp_rdy = 1'b1;
    #1;
    chk("s4_release", mem_if.resp_rdy, 1);
    @(negedge clk);
    #1;
    chk("s4_popped", num_outstanding, 2);
    chk("s4_next_i", imem_if.resp_val, 1);
    @(negedge clk);
    #1;
    chk("s4_last_i", imem_if.resp_val, 1);
    @(negedge clk);
    #1;
    chk("s4_empty", num_outstanding, 0);

    // Stray response with empty FIFO is never accepted.
    chk("s5_rdy", mem_if.resp_rdy, 0);
    chk("s5_ival", imem_if.resp_val, 0);
    chk("s5_dval", dmem_if.resp_val, 0);
    @(negedge clk);
    mem_if.resp_val = 1'b0;
    #1;
    chk("s5_cnt", num_outstanding, 0);

    // Two outstanding (imem then dmem, leaving imem favoured), then async reset.
    @(negedge clk);
    imem_if.req_msg = mk_req(8'h60, 32'h600);
    imem_if.req_val = 1'b1;
    @(negedge clk);
    imem_if.req_val = 1'b0;
    dmem_if.req_msg = mk_req(8'h61, 32'h610);
    dmem_if.req_val = 1'b1;
    @(negedge clk);
    im_msg = mk_req(8'h70, 32'h700);
    dm_msg = mk_req(8'h71, 32'h710);
    imem_if.req_msg = im_msg;
    dmem_if.req_msg = dm_msg;
    imem_if.req_val = 1'b1;
    mem_if.resp_val = 1'b1;
    #1;
    chk("s6_cnt2", num_outstanding, 2);
    chk("s6_prio_i", mem_if.req_msg, im_msg);
    #1;
    reset = 1'b0;
    #1;
    chk("s6_rst_val", mem_if.req_val, 0);
    chk("s6_rst_irdy", imem_if.req_rdy, 0);
    chk("s6_rst_drdy", dmem_if.req_rdy, 0);
    chk("s6_rst_cnt", num_outstanding, 0);
    chk("s6_rst_resp_rdy", mem_if.resp_rdy, 0);
    chk("s6_rst_ival", imem_if.resp_val, 0);
    @(negedge clk);
    mem_if.resp_val = 1'b0;
    reset = 1'b1;
    #1;
    chk("s6_post_msg", mem_if.req_msg, dm_msg);
    chk("s6_post_drdy", dmem_if.req_rdy, 1);
    chk("s6_post_irdy", imem_if.req_rdy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
